// File: rtl/pmem_pkg.sv
// Shared physical-memory definitions: responder FSM states, line geometry helpers
// and the line type that the cache controllers also import.
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  localparam int PMEM_LINE_BYTES = 32;
  localparam int PMEM_LINE_W     = PMEM_LINE_BYTES * 8;
  localparam int PMEM_OFF        = $clog2(PMEM_LINE_BYTES);

  typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

  // Number of byte-offset bits below the line index for a given line size.
  function automatic int pmem_off(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port synchronous line RAM with one write enable and an enabled,
// resettable output register that holds the last line read.
module line_mem_array #(
  parameter  int DEPTH_LINES = 512,
  parameter  int LINE_W      = 256,
  localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  // Storage is deliberately not reset; contents survive rst.
  logic [LINE_W-1:0] r_mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_idx];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Physical-memory responder: one full-line read/write at a time, held with mem_retry for
// READ/WRITE_LATENCY cycles after the request is sampled, then a one-cycle mem_resp.
import pmem_pkg::*;

module line_mem_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_BYTES    = 32,
  parameter int DEPTH_LINES   = 512,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_action_stb,
  input  logic                    mem_action_cyc,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [LINE_BYTES*8-1:0] mem_wdata,
  output logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic                    mem_resp,
  output logic                    mem_retry
);

  localparam int LINE_W  = LINE_BYTES * 8;
  localparam int OFF     = pmem_off(LINE_BYTES);
  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 2);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 2);

  pmem_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [LINE_W-1:0] r_wdata;

  logic              w_req;
  logic              w_commit;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_unused_addr;

  assign w_req     = mem_action_stb & mem_action_cyc;
  assign w_req_idx = mem_address[OFF +: IDX_W];
  // Offset and upper address bits are intentionally dropped (lines alias).
  assign w_unused_addr = ^mem_address;

  // The BUSY->RESP edge; rst on the same edge suppresses the commit.
  assign w_commit = (r_state == BUSY) && w_req && (r_cnt == '0) && !rst;

  assign mem_retry = w_req & ~r_resp;
  assign mem_resp  = r_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_req_idx;
            r_write <= mem_write;
            r_wdata <= mem_wdata;
            r_cnt   <= mem_write ? WR_LOAD : RD_LOAD;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  line_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .LINE_W      (LINE_W)
  ) u_array (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_commit & r_write),
    .i_re    (w_commit & ~r_write),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench: instance 0 uses default latencies (4/4), instance 1 uses READ=2/WRITE=6.
module tb_line_mem_responder;

  localparam int LB = 32;
  localparam int DL = 512;
  typedef logic [LB*8-1:0] line_t;

  typedef struct {
    int    dut;
    int    cyc;
    bit    is_rd;
    line_t data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb   [2];
  logic        cyc   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  line_t       wdata [2];
  line_t       rdata [2];
  logic        resp  [2];
  logic        retry [2];

  int    cyc_cnt = 0;
  int    checks  = 0;
  int    errors  = 0;
  bit    mon_en  = 0;
  bit    in_resp = 0;
  exp_t  sb [$];
  line_t mem0 [int];
  line_t mem1 [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  line_mem_responder u_dut0 (
    .clk(clk), .rst(rst),
    .mem_action_stb(stb[0]), .mem_action_cyc(cyc[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_resp(resp[0]), .mem_retry(retry[0])
  );

  line_mem_responder #(.READ_LATENCY(2), .WRITE_LATENCY(6)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_action_stb(stb[1]), .mem_action_cyc(cyc[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_resp(resp[1]), .mem_retry(retry[1])
  );

  task automatic chk(input string name, input logic [LB*8-1:0] act, input logic [LB*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h required %h", name, cyc_cnt, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / LB) % DL);
  endfunction

  function automatic int lat_of(input int d, input bit w);
    if (d == 0) return 4;
    return w ? 6 : 2;
  endfunction

  // Issue one transaction; with hold=1 the request stays up into the next one.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input line_t data,
                     input bit hold, input bit scramble);
    exp_t e;
    int   lat;
    int   idx;
    int   skip;
    lat  = lat_of(d, w);
    idx  = line_idx(a);
    skip = in_resp ? 1 : 0;
    stb[d] = 1'b1; cyc[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = data;
    e.dut   = d;
    e.cyc   = cyc_cnt + skip + lat;
    e.is_rd = !w;
    e.data  = '0;
    if (w) begin
      if (d == 0) mem0[idx] = data; else mem1[idx] = data;
    end else begin
      e.data = (d == 0) ? mem0[idx] : mem1[idx];
    end
    sb.push_back(e);
    if (skip != 0) tick();
    for (int i = 0; i < lat; i++) begin
      tick();
      if (scramble && i < lat - 1) begin
        addr[d]  = $urandom;
        wr[d]    = 1'($urandom);
        wdata[d] = {8{$urandom}};
      end
    end
    if (hold) begin
      in_resp = 1;
    end else begin
      stb[d] = 1'b0; cyc[d] = 1'b0;
      in_resp = 0;
      tick();
    end
  endtask

  // Monitor: every cycle compare resp/retry against the queue front, and read data on resp.
  always @(negedge clk) begin
    logic exp_resp;
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_resp = (sb.size() > 0) && (sb[0].dut == d) && (sb[0].cyc == cyc_cnt);
        chk($sformatf("retry%0d", d), {255'd0, retry[d]}, {255'd0, stb[d] & cyc[d] & ~exp_resp});
        chk($sformatf("resp%0d", d), {255'd0, resp[d]}, {255'd0, exp_resp});
        if (exp_resp) begin
          e = sb.pop_front();
          if (e.is_rd) chk($sformatf("rdata%0d", d), rdata[d], e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t       a5, ff, x, oldv, newv, d1, d2;
    logic [31:0] a;
    int          idx, gap;
    bit          w, h;
    a5 = {8{32'hA5A5_A5A5}};
    ff = {8{32'hFFFF_FFFF}};
    x  = {8{32'h1234_5678}};
    d1 = {8{32'hC0DE_0001}};
    d2 = {8{32'hBEEF_0002}};

    // Reset held 2 cycles with a request pending on instance 0.
    rst = 1'b1;
    stb[0] = 1'b1; cyc[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h100; wdata[0] = d1;
    stb[1] = 1'b0; cyc[1] = 1'b0; wr[1] = 1'b0; addr[1] = '0;     wdata[1] = '0;
    tick();
    mon_en = 1;
    chk("rst_rdata0_c1", rdata[0], '0);
    chk("rst_rdata1_c1", rdata[1], '0);
    tick();
    chk("rst_rdata0_c2", rdata[0], '0);
    chk("rst_rdata1_c2", rdata[1], '0);
    rst = 1'b0;
    txn(0, 1, 32'h100, d1, 0, 0);

    // Write then read with a different offset in the same line.
    txn(0, 1, 32'h0000_0040, a5, 0, 0);
    txn(0, 0, 32'h0000_0044, '0, 0, 0);

    // Abort: write to 0x80 dropped in the second BUSY cycle.
    oldv = {8{32'h0BAD_F00D}};
    txn(0, 1, 32'h80, oldv, 0, 0);
    stb[0] = 1'b1; cyc[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h80; wdata[0] = ff;
    tick(); tick();
    cyc[0] = 1'b0;
    tick();
    stb[0] = 1'b0;
    repeat (6) tick();
    txn(0, 0, 32'h80, '0, 0, 0);

    // Reset on the BUSY->RESP edge of a write: nothing committed, rdata cleared.
    oldv = {8{32'h5555_AAAA}};
    newv = {8{32'h9999_6666}};
    txn(0, 1, 32'h60, oldv, 0, 0);
    stb[0] = 1'b1; cyc[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h60; wdata[0] = newv;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stb[0] = 1'b0; cyc[0] = 1'b0;
    chk("midrst_rdata0", rdata[0], '0);
    tick();
    txn(0, 0, 32'h60, '0, 0, 0);

    // Aliasing: index 5 and index 5 + DEPTH_LINES lines.
    txn(0, 1, 32'(5 * LB), x, 0, 0);
    txn(0, 0, 32'(5 * LB + DL * LB), '0, 0, 0);

    // Back-to-back on instance 1, request held across four transactions.
    txn(1, 1, 32'h200, d1, 1, 0);
    txn(1, 0, 32'h204, '0, 1, 0);
    txn(1, 1, 32'h300, d2, 1, 0);
    txn(1, 0, 32'h31F, '0, 0, 0);

    // Randomized mix on both instances, with field scrambling during BUSY.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        idx = $urandom_range(0, 15);
        a   = ($urandom & ~32'h0000_3FE0) | 32'(idx * LB);
        w   = 1'($urandom);
        if (!w && !((d == 0) ? mem0.exists(idx) : mem1.exists(idx))) w = 1'b1;
        h   = (n != 39) && ($urandom_range(0, 2) == 0);
        txn(d, w, a, {8{$urandom}}, h, 1'($urandom));
        if (!h) begin
          gap = $urandom_range(0, 2);
          repeat (gap) tick();
        end
      end
    end

    repeat (10) tick();
    chk("scoreboard_drained", 256'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
